spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Round-robin scheduler that shares one `spi_module` instance in master mode (`SPI_MASTER=1`) between up to four requesters. It sits between the requesting logic and the SPI core. It drives the core's `process_next_word` / `data_word_send` handshake, word by word. A requester keeps the link for a whole burst, which ends on the word flagged `last`. It then hands the link to the next requester in round-robin order.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `WORD_LEN`, 8: SPI word width in bits; must match the core.
- `GAP_CYCLES`, 2: idle `master_clock` cycles inserted after each completed word; 0 means no gap; counter width 8 bits.
- `TIMEOUT_CYCLES`, 1023: watchdog limit; used only when `SPI_ARB_TIMEOUT_EN` is defined.

Ports:
- `master_clock` in 1: single clock. All logic runs on its rising edge.
- `do_reset_n` in 1: asynchronous, active-low reset.
- `spi_is_ready` in 1: the core's `is_ready`. No grant is issued while it is 0.
- `req_valid` in NUM_REQ: requester *i* has a word available.
- `req_last` in NUM_REQ: the presented word ends requester *i*'s burst.
- `req_data` in NUM_REQ*WORD_LEN: requester *i*'s word is in bits `[i*WORD_LEN +: WORD_LEN]`.
- `req_ack` out NUM_REQ: one-cycle pulse when requester *i*'s word is latched. The requester presents its next word from the following cycle.
- `process_next_word` out 1: goes to the core.
- `data_word_send` out WORD_LEN: goes to the core.
- `processing_word` in 1: comes from the core.
- `word_done` out 1: one-cycle pulse when the core finishes a word.
- `grant_id` out 2: index of the requester that currently holds the link.
- `busy` out 1: high in every state except IDLE.
- `error` out 1: sticky watchdog flag. Always 0 when `SPI_ARB_TIMEOUT_EN` is not defined.

## Operation
States: IDLE, LOAD, SHIFT, GAP, HOLD.

Reset values (asynchronous):
- state = IDLE
- `process_next_word` = 0, `data_word_send` = 0, `req_ack` = 0, `word_done` = 0
- `grant_id` = 0, `busy` = 0, `error` = 0
- round-robin pointer `rr_ptr` = NUM_REQ-1, so requester 0 has first priority.

State behaviour:
- **IDLE**: if `spi_is_ready` = 1 and any `req_valid` bit is set, select the first valid requester searching from index `rr_ptr`+1 upward, with wrap-around. On that edge:
  - set `grant_id`;
  - latch `req_data` and `req_last` for that requester;
  - pulse its `req_ack`;
  - go to LOAD.
- **LOAD**: `process_next_word` = 1. When `processing_word` = 1 is sampled, clear `process_next_word` and go to SHIFT.
- **SHIFT**: when `processing_word` = 0 is sampled, pulse `word_done`. Go to GAP if GAP_CYCLES > 0; otherwise go directly to the GAP exit decision.
- **GAP**: count GAP_CYCLES cycles, then take the exit decision:
  - if the latched `last` = 1: set `rr_ptr` = `grant_id` and go to IDLE;
  - else if `req_valid[grant_id]` = 1: latch the next word, pulse `req_ack`, and go to LOAD;
  - else go to HOLD.
- **HOLD**: the grant is kept, so a burst is never interleaved with another requester's words. Stay in HOLD until `req_valid[grant_id]` = 1, then latch the word, pulse `req_ack`, and go to LOAD.

Other rules:
- `data_word_send` is held stable from the latch until the next latch.
- Changes on `req_valid` or `req_data` of a non-granted requester have no effect during a burst.
- If `spi_is_ready` falls outside IDLE, the current word still completes. No new burst starts until `spi_is_ready` returns to 1.
- Reset asserted mid-word returns all state and outputs to their reset values immediately, and the pending word is discarded.

## Timing
- Grant latency: the `req_ack` pulse and the LOAD entry happen one edge after `req_valid` is seen in IDLE.
- `process_next_word` rises in the first LOAD cycle. It falls on the edge after `processing_word` is sampled high.
- `word_done` is asserted in the cycle after `processing_word` is sampled low.
- Between consecutive words of one burst, the minimum spacing from the `word_done` pulse to the next `process_next_word` rise is GAP_CYCLES+1 cycles.
- Back-to-back bursts add one IDLE cycle between the end of one burst and the grant of the next.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined: a 10-bit watchdog counts cycles spent in LOAD without `processing_word` rising, and cycles spent in SHIFT without `processing_word` falling.
  - When the count reaches TIMEOUT_CYCLES: set `error` = 1 (cleared only by reset), drop `process_next_word`, give no `word_done` pulse, set `rr_ptr` = `grant_id`, and return to IDLE.
- Not defined: no counter is built, the arbiter waits indefinitely, and `error` is tied to 0.

## Test plan
- Single requester burst: req0 sends 3 words 0x01, 0x02, 0x03 with `last` on the third word, core model active → 3 `req_ack` pulses, `data_word_send` takes 0x01, 0x02, 0x03 in order, 3 `word_done` pulses, final state IDLE, `rr_ptr` = 0.
- Round-robin: `req_valid` = 4'b1111, each requester sends single-word bursts with `last`=1 → grants occur in order 0, 1, 2, 3, 0.
- Burst atomicity: req1 drops `req_valid` mid-burst while req0 is valid → state HOLD, `grant_id` stays 1, no `req_ack` to req0 until req1 finishes its burst.
- Gap: GAP_CYCLES=5 → exactly 6 cycles between the `word_done` pulse and the next `process_next_word` rise.
- Reset mid-SHIFT: `do_reset_n` pulled low → all outputs return to reset values in the same cycle, and the next grant after reset goes to requester 0.
- With `SPI_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=20, `processing_word` held at 0 → after 20 LOAD cycles `error` = 1, state IDLE, and a subsequent normal word completes normally.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master core among up to four requesters, burst by burst.
// Optional build macro SPI_ARB_TIMEOUT_EN adds a LOAD/SHIFT watchdog that raises a sticky error.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int WORD_LEN       = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        master_clock,
  input  logic                        do_reset_n,
  input  logic                        spi_is_ready,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*WORD_LEN-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic                        process_next_word,
  output logic [WORD_LEN-1:0]         data_word_send,
  input  logic                        processing_word,
  output logic                        word_done,
  output logic [1:0]                  grant_id,
  output logic                        busy,
  output logic                        error
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, HOLD} state_t;

  state_t              state_reg;
  logic [1:0]          rr_ptr_reg;
  logic                last_reg;
  logic [7:0]          gap_cnt_reg;
  logic [3:0]          ack_reg;
  logic                wd_expired;

  // Requester views padded to four entries so a 2-bit index is always in range.
  logic [3:0]          valid_pad;
  logic [3:0]          last_pad;
  logic [WORD_LEN-1:0] word_pad [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_pad
    if (gi < NUM_REQ) begin : g_used
      assign valid_pad[gi] = req_valid[gi];
      assign last_pad[gi]  = req_last[gi];
      assign word_pad[gi]  = req_data[gi*WORD_LEN +: WORD_LEN];
    end else begin : g_unused
      assign valid_pad[gi] = 1'b0;
      assign last_pad[gi]  = 1'b0;
      assign word_pad[gi]  = '0;
    end
  end

  assign req_ack = ack_reg[NUM_REQ-1:0];
  assign busy    = (state_reg != IDLE);

  // Scan from farthest to nearest so the requester closest after rr_ptr wins.
  logic [1:0] sel_id;
  logic       sel_valid;
  logic [1:0] scan_idx;

  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = 2'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (valid_pad[scan_idx]) begin
        sel_valid = 1'b1;
        sel_id    = scan_idx;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [9:0] wd_cnt_reg;
  logic       error_reg;
  logic       wd_counting;

  assign wd_counting = ((state_reg == LOAD) && !processing_word) ||
                       ((state_reg == SHIFT) && processing_word);
  assign wd_expired  = wd_counting && (wd_cnt_reg == 10'(TIMEOUT_CYCLES - 1));
  assign error       = error_reg;

  always_ff @(posedge master_clock or negedge do_reset_n) begin
    if (!do_reset_n) begin
      wd_cnt_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      wd_cnt_reg <= wd_counting ? wd_cnt_reg + 10'd1 : 10'd0;
      if (wd_expired) begin
        error_reg <= 1'b1;
      end
    end
  end
`else
  assign wd_expired = 1'b0;
  assign error      = 1'b0;
`endif

  always_ff @(posedge master_clock or negedge do_reset_n) begin
    if (!do_reset_n) begin
      state_reg         <= IDLE;
      rr_ptr_reg        <= 2'(NUM_REQ - 1);
      last_reg          <= 1'b0;
      gap_cnt_reg       <= '0;
      ack_reg           <= '0;
      process_next_word <= 1'b0;
      data_word_send    <= '0;
      word_done         <= 1'b0;
      grant_id          <= '0;
    end else begin
      ack_reg   <= '0;
      word_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (spi_is_ready && sel_valid) begin
            grant_id          <= sel_id;
            data_word_send    <= word_pad[sel_id];
            last_reg          <= last_pad[sel_id];
            ack_reg[sel_id]   <= 1'b1;
            process_next_word <= 1'b1;
            state_reg         <= LOAD;
          end
        end
        LOAD: begin
          if (wd_expired) begin
            process_next_word <= 1'b0;
            rr_ptr_reg        <= grant_id;
            state_reg         <= IDLE;
          end else if (processing_word) begin
            process_next_word <= 1'b0;
            state_reg         <= SHIFT;
          end
        end
        SHIFT: begin
          if (wd_expired) begin
            rr_ptr_reg <= grant_id;
            state_reg  <= IDLE;
          end else if (!processing_word) begin
            word_done   <= 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end
        end
        // GAP always lasts GAP_CYCLES+1 cycles; the final one is the exit decision.
        GAP: begin
          if (gap_cnt_reg == 8'(GAP_CYCLES)) begin
            if (last_reg) begin
              rr_ptr_reg <= grant_id;
              state_reg  <= IDLE;
            end else if (valid_pad[grant_id]) begin
              data_word_send    <= word_pad[grant_id];
              last_reg          <= last_pad[grant_id];
              ack_reg[grant_id] <= 1'b1;
              process_next_word <= 1'b1;
              state_reg         <= LOAD;
            end else begin
              state_reg <= HOLD;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 8'd1;
          end
        end
        HOLD: begin
          if (valid_pad[grant_id]) begin
            data_word_send    <= word_pad[grant_id];
            last_reg          <= last_pad[grant_id];
            ack_reg[grant_id] <= 1'b1;
            process_next_word <= 1'b1;
            state_reg         <= LOAD;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a simple SPI core model answering the word handshake.
// Define SPI_ARB_TIMEOUT_EN to also exercise the watchdog.
`timescale 1ns/1ps
module tb_spi_master_arbiter;
  localparam int NR = 4;
  localparam int WL = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           spi_is_ready = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_last = '0;
  logic [NR*WL-1:0] req_data = '0;
  logic [NR-1:0]  req_ack;
  logic           pnw;
  logic [WL-1:0]  data_word_send;
  logic           processing_word;
  logic           word_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           error;

  int checks = 0;
  int errors = 0;

  spi_master_arbiter #(.NUM_REQ(NR), .WORD_LEN(WL), .GAP_CYCLES(5), .TIMEOUT_CYCLES(20)) dut (
    .master_clock(clk), .do_reset_n(rst_n), .spi_is_ready(spi_is_ready),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ack(req_ack),
    .process_next_word(pnw), .data_word_send(data_word_send), .processing_word(processing_word),
    .word_done(word_done), .grant_id(grant_id), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Core model: busy for 3 cycles after seeing a word request.
  logic core_en = 1'b1;
  int   pw_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      processing_word <= 1'b0;
      pw_cnt          <= 0;
    end else if (core_en) begin
      if (!processing_word && pnw) begin
        processing_word <= 1'b1;
        pw_cnt          <= 3;
      end else if (processing_word) begin
        if (pw_cnt == 1) processing_word <= 1'b0;
        pw_cnt <= pw_cnt - 1;
      end
    end
  end

  // Transaction monitor
  int         cyc = 0;
  int         ack_q[$];
  logic [7:0] dat_q[$];
  int         done_q[$];
  int         rise_q[$];
  logic       pnw_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (req_ack[i]) begin
        ack_q.push_back(i);
        dat_q.push_back(data_word_send);
        $display("[%0t] ack req%0d data=0x%02h", $time, i, data_word_send);
      end
    end
    if (word_done) done_q.push_back(cyc);
    if (pnw && !pnw_prev) rise_q.push_back(cyc);
    pnw_prev <= pnw;
  end

  task automatic clear_logs();
    ack_q.delete(); dat_q.delete(); done_q.delete(); rise_q.delete();
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic last, input logic valid);
    req_data[i*WL +: WL] = d;
    req_last[i]  = last;
    req_valid[i] = valid;
  endtask

  task automatic wait_ack(input int i, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ack[i] && n < 60);
    checks++;
    if (req_ack[i] !== 1'b1) begin
      errors++; $display("FAIL ack_wait_req%0d: ack=%0b after %0d cycles, required 1", i, req_ack[i], n);
    end
  endtask

  task automatic wait_acks(input int cnt);
    int n = 0;
    while (ack_q.size() < cnt && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (ack_q.size() < cnt) begin
      errors++; $display("FAIL ack_count_wait: got %0d acks, required %0d", ack_q.size(), cnt);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_wait: busy=%0b, required 0", busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({pnw, word_done, busy, error} !== 4'b0000 || data_word_send !== 8'h00 ||
        req_ack !== 4'h0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL %s: pnw=%0b done=%0b busy=%0b err=%0b data=%02h ack=%b grant=%0d, required all 0",
               tag, pnw, word_done, busy, error, data_word_send, req_ack, grant_id);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_round_robin();
    clear_logs();
    for (int i = 0; i < NR; i++) set_req(i, 8'(8'h10 + i), 1'b1, 1'b1);
    wait_acks(5);
    req_valid = '0;
    wait_idle();
    for (int k = 0; k < 5; k++) begin
      if (k < ack_q.size()) begin
        checks++;
        if (ack_q[k] !== k % 4 || dat_q[k] !== 8'(8'h10 + k % 4)) begin
          errors++; $display("FAIL rr_order_%0d: grant=%0d data=%02h, required grant=%0d data=%02h",
                             k, ack_q[k], dat_q[k], k % 4, 8'(8'h10 + k % 4));
        end
      end
    end
  endtask

  task automatic test_single_burst();
    int n;
    clear_logs();
    for (int w = 1; w <= 3; w++) begin
      set_req(0, 8'(w), (w == 3), 1'b1);
      wait_ack(0, n);
      checks++;
      if (data_word_send !== 8'(w)) begin
        errors++; $display("FAIL burst_data_%0d: got %02h, required %02h", w, data_word_send, 8'(w));
      end
    end
    req_valid[0] = 1'b0;
    wait_idle();
    checks++;
    if (ack_q.size() != 3 || done_q.size() != 3) begin
      errors++; $display("FAIL burst_counts: acks=%0d done=%0d, required 3 and 3", ack_q.size(), done_q.size());
    end
    // rr_ptr now 0: with req0 and req1 both valid, req1 must be served first.
    clear_logs();
    set_req(0, 8'h30, 1'b1, 1'b1);
    set_req(1, 8'h31, 1'b1, 1'b1);
    wait_acks(1);
    req_valid[1] = 1'b0;
    wait_acks(2);
    req_valid[0] = 1'b0;
    wait_idle();
    checks++;
    if (ack_q.size() != 2 || ack_q[0] != 1 || ack_q[1] != 0) begin
      errors++; $display("FAIL rr_after_burst: order size=%0d first=%0d, required 1 then 0",
                         ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1);
    end
  endtask

  task automatic test_burst_atomicity();
    int n;
    clear_logs();
    set_req(0, 8'h40, 1'b1, 1'b1);
    set_req(1, 8'h41, 1'b0, 1'b1);
    wait_ack(1, n);
    req_valid[1] = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd1 || pnw !== 1'b0 || data_word_send !== 8'h41) begin
      errors++; $display("FAIL hold_state: busy=%0b grant=%0d pnw=%0b data=%02h, required 1 1 0 41",
                         busy, grant_id, pnw, data_word_send);
    end
    checks++;
    if (ack_q.size() != 1) begin
      errors++; $display("FAIL hold_no_ack: acks=%0d, required 1", ack_q.size());
    end
    set_req(1, 8'h42, 1'b1, 1'b1);
    wait_ack(1, n);
    checks++;
    if (data_word_send !== 8'h42) begin
      errors++; $display("FAIL hold_resume_data: got %02h, required 42", data_word_send);
    end
    req_valid[1] = 1'b0;
    wait_acks(3);
    req_valid[0] = 1'b0;
    wait_idle();
    checks++;
    if (ack_q.size() != 3 || ack_q[2] != 0 || dat_q[2] !== 8'h40) begin
      errors++; $display("FAIL atomic_next_grant: acks=%0d, required third ack to req0 with data 40", ack_q.size());
    end
  endtask

  task automatic test_not_ready();
    int n;
    clear_logs();
    spi_is_ready = 1'b0;
    set_req(1, 8'h71, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (ack_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL not_ready_grant: acks=%0d busy=%0b, required 0 0", ack_q.size(), busy);
    end
    spi_is_ready = 1'b1;
    wait_ack(1, n);
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL ready_latency: got %0d cycles, required 1", n);
    end
    req_valid[1] = 1'b0;
    wait_idle();
  endtask

  task automatic test_gap();
    int n;
    clear_logs();
    set_req(2, 8'h51, 1'b0, 1'b1);
    wait_ack(2, n);
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL grant_latency: got %0d cycles, required 1", n);
    end
    set_req(2, 8'h52, 1'b1, 1'b1);
    wait_ack(2, n);
    checks++;
    if (data_word_send !== 8'h52) begin
      errors++; $display("FAIL gap_second_data: got %02h, required 52", data_word_send);
    end
    req_valid[2] = 1'b0;
    wait_idle();
    checks++;
    if (rise_q.size() != 2 || done_q.size() != 2) begin
      errors++; $display("FAIL gap_events: rises=%0d done=%0d, required 2 and 2", rise_q.size(), done_q.size());
    end else begin
      checks++;
      if (rise_q[1] - done_q[0] != 6) begin
        errors++; $display("FAIL gap_spacing: got %0d cycles, required 6", rise_q[1] - done_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int n = 0;
    clear_logs();
    set_req(3, 8'h61, 1'b1, 1'b1);
    wait_ack(3, n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(processing_word && !pnw) && n < 20);
    checks++;
    if (!(processing_word && !pnw)) begin
      errors++; $display("FAIL reach_shift: pw=%0b pnw=%0b, required 1 0", processing_word, pnw);
    end
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_shift");
    for (int i = 0; i < NR; i++) set_req(i, 8'(8'h60 + i), 1'b1, 1'b1);
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    wait_acks(1);
    req_valid = '0;
    wait_idle();
    checks++;
    if (ack_q.size() < 1 || ack_q[0] != 0) begin
      errors++; $display("FAIL post_reset_grant: got %0d, required 0", (ack_q.size() > 0) ? ack_q[0] : -1);
    end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    clear_logs();
    core_en = 1'b0;
    set_req(0, 8'h81, 1'b1, 1'b1);
    wait_ack(0, n);
    req_valid[0] = 1'b0;
    n = 0;
    while (error !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (error !== 1'b1 || n != 20) begin
      errors++; $display("FAIL timeout_cycles: error=%0b after %0d cycles, required 1 after 20", error, n);
    end
    checks++;
    if (busy !== 1'b0 || pnw !== 1'b0 || done_q.size() != 0) begin
      errors++; $display("FAIL timeout_abort: busy=%0b pnw=%0b done=%0d, required 0 0 0", busy, pnw, done_q.size());
    end
    core_en = 1'b1;
    set_req(1, 8'h82, 1'b1, 1'b1);
    wait_ack(1, n);
    req_valid[1] = 1'b0;
    wait_idle();
    checks++;
    if (done_q.size() != 1 || error !== 1'b1) begin
      errors++; $display("FAIL timeout_recover: done=%0d error=%0b, required 1 1", done_q.size(), error);
    end
  endtask
`else
  task automatic test_timeout();
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL error_tied_low: got %0b, required 0", error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_burst();
    test_burst_atomicity();
    test_not_ready();
    test_gap();
    test_reset_mid_shift();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "bench time budget exhausted");
  end

endmodule
